// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader that fills instruction memory from a length-prefixed byte stream
// Holds the fetch path while a load runs and reports the loaded program size.
module imem_loader #(
  parameter int MAX_WORDS = 8192
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_data,
  output logic        o_in_ready,
  output logic        o_imem_we,
  output logic [12:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [13:0] o_prog_size
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_BYTE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len_hi;
  logic [13:0] r_count;
  logic [13:0] r_words;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_wdata;
  logic [12:0] r_addr;
  logic        r_err;
  logic [13:0] r_prog_size;

  logic        w_xfer;
  logic [15:0] w_count;
  logic        w_count_zero;
  logic        w_count_big;
  logic [13:0] w_words_inc;
  logic        w_last_word;

  assign w_xfer       = i_in_valid && o_in_ready;
  assign w_count      = {r_len_hi, i_in_data};
  assign w_count_zero = (w_count == 16'd0);
  assign w_count_big  = (32'(w_count) > MAX_WORDS);
  assign w_words_inc  = r_words + 14'd1;
  assign w_last_word  = (w_words_inc == r_count);

  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_err        = r_err;
  assign o_prog_size  = r_prog_size;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_in_ready = 1'b0;
    o_imem_we  = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        o_in_ready = 1'b1;
        if (w_xfer) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        o_in_ready = 1'b1;
        if (w_xfer) begin
          if (w_count_zero || w_count_big) w_next = S_DONE;
          else                             w_next = S_BYTE;
        end
      end
      S_BYTE: begin
        o_in_ready = 1'b1;
        if (w_xfer && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_imem_we = 1'b1;
        w_next    = w_last_word ? S_DONE : S_BYTE;
      end
      S_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
        if (i_start) w_next = S_LEN_HI;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_cpu_hold = o_busy;

  // prog_size is only touched on entry to DONE, so it stays stable during a new load
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_len_hi    <= 8'd0;
      r_count     <= 14'd0;
      r_words     <= 14'd0;
      r_byte_cnt  <= 2'd0;
      r_wdata     <= 32'd0;
      r_addr      <= 13'd0;
      r_err       <= 1'b0;
      r_prog_size <= 14'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_addr     <= 13'd0;
            r_words    <= 14'd0;
            r_byte_cnt <= 2'd0;
            r_err      <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) r_len_hi <= i_in_data;
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            if (w_count_big) begin
              r_err       <= 1'b1;
              r_prog_size <= 14'd0;
            end else if (w_count_zero) begin
              r_prog_size <= 14'd0;
            end else begin
              r_count <= w_count[13:0];
            end
          end
        end
        S_BYTE: begin
          if (w_xfer) begin
            r_wdata    <= {r_wdata[23:0], i_in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          r_words <= w_words_inc;
          if (w_last_word) r_prog_size <= w_words_inc;
          else             r_addr      <= r_addr + 13'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that fills the 8192 x 32-bit instruction memory from a byte stream instead of a simulation file preload. It accepts a length header and then instruction bytes over a valid/ready handshake, assembles each group of four bytes into a 32-bit word, and writes the words to consecutive word addresses starting at 0. While loading, it holds the fetch path (PC, adder, instruction memory read) in stall. When loading finishes, it reports the program size so end-of-program detection can compare the PC against it.

## Interface
- MAX_WORDS, 8192, instruction memory depth in words; the address is 13 bits wide.

- clk  input  1  master clock; all state updates on the positive edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  13  word address for the write
- imem_wdata  output  32  assembled instruction word
- cpu_hold  output  1  stalls the fetch path while high
- busy  output  1  a load is in progress
- done  output  1  load finished; held until the next accepted start
- err  output  1  header exceeded MAX_WORDS; held until the next accepted start
- prog_size  output  14  number of words written by the last completed load

## Operation
- States and transitions:
  - IDLE: start -> LEN_HI.
  - LEN_HI: byte accepted -> LEN_LO.
  - LEN_LO: byte accepted -> the 16-bit count {hi,lo} is formed, then:
    - count == 0 -> DONE, with prog_size = 0.
    - count > MAX_WORDS -> DONE, with err = 1 and no writes.
    - otherwise -> BYTE.
  - BYTE: collect 4 bytes, then -> WRITE.
  - WRITE: imem_we = 1 for one cycle. Afterwards:
    - words_written + 1 == count -> DONE.
    - otherwise -> BYTE at imem_addr + 1.
  - DONE: start -> LEN_HI, clearing done and err.
- Byte order is big-endian. The first byte of a word lands in bits [31:24] and the fourth in bits [7:0].
- A byte transfer occurs on a rising edge where in_valid && in_ready are both high. in_data is ignored at all other times.
- in_ready is 1 in LEN_HI, LEN_LO and BYTE, and 0 in IDLE, WRITE and DONE.
- busy and cpu_hold are both 1 in every state except IDLE and DONE.
- prog_size:
  - Updated on entry to DONE to the number of words written.
  - Set to 0 on the error path.
  - Remains stable while a new load runs.
- imem_addr starts at 0 on every accepted start. It never exceeds MAX_WORDS-1 because the count is checked against MAX_WORDS before any write.
- The byte counter is 2 bits and wraps from 3 to 0. The word counter is 14 bits.
- start in any state other than IDLE or DONE is ignored.
- start arriving in the same cycle as a byte in LEN_HI has no effect; the byte is consumed normally.

## Timing
- On reset assertion the block enters IDLE immediately, with no clock needed.
  - Every output is 0, including imem_addr, imem_wdata and prog_size.
  - Reset mid-load aborts the load with no further writes. Memory contents written so far remain.
- start is sampled at edge N; the state is LEN_HI and in_ready = 1 from edge N onward.
- The 4th byte of a word is accepted at edge M. imem_we, imem_addr and imem_wdata are then valid for the cycle between edges M and M+1, and the memory captures the word at edge M+1.
- With no stalls the throughput is 1 word per 5 cycles.
- done rises at the edge where WRITE exits, or at the edge that accepts the LEN_LO byte when count is zero or too large.
- cpu_hold falls in the same cycle that done rises. The first fetch from address 0 occurs no earlier than the edge after that.
- Gaps in in_valid stall the loader with no state change. Partial-word bytes are retained across the gap.

## Test plan
- Basic load:
  - Stimulus: start; bytes 00 02, DE AD BE EF, 12 34 56 78.
  - Required response: writes DEADBEEF at address 0, then 12345678 at address 1; done = 1, prog_size = 2; cpu_hold falls together with done; imem_we is high for exactly 2 cycles.
- Zero length:
  - Stimulus: start; bytes 00 00.
  - Required response: done = 1 one edge after the second byte; imem_we never high; prog_size = 0, err = 0.
- Oversize header:
  - Stimulus: start; bytes 20 01 (8193).
  - Required response: err = 1, done = 1, no writes, prog_size = 0; a second start clears err.
- Handshake gaps:
  - Stimulus: in_valid deasserted for 3 cycles between the 2nd and 3rd bytes of a word.
  - Required response: word assembled correctly, with a single write at the expected address.
- Reset mid-word:
  - Stimulus: assert reset after 2 bytes of word 1.
  - Required response: all outputs 0 immediately; no write occurs. A following start plus a full stream loads correctly from address 0.
- Start while busy:
  - Stimulus: start pulse during BYTE state.
  - Required response: ignored; imem_addr sequence and final prog_size are unchanged from the unperturbed load.
